// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point adder/subtractor.
// unpack/align -> add -> normalise/round/pack, global stall on backpressure.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  // mantissa datapath: hidden, frac, guard, round, sticky
  localparam int MW  = MAN_W + 4;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EMAX  = '1;
  localparam logic [EXP_W-1:0] SHMAX = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_adv;

  // ---------------- stage 1: unpack / align ----------------
  logic               w_sa, w_sb, w_sl, w_ss, w_swap;
  logic [EXP_W-1:0]   w_ea, w_eb, w_el, w_es, w_d;
  logic [MAN_W-1:0]   w_fa, w_fb;
  logic [W-2:0]       w_mag_a, w_mag_b, w_mag_l, w_mag_s;
  logic [MAN_W:0]     w_ml, w_ms;
  logic [2*MW-1:0]    w_sh;
  logic [MW-1:0]      w_ms_al;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic               w_spec, w_spec_inv;
  logic [W-1:0]       w_spec_res;

  assign w_sa = a[W-1];
  assign w_sb = b[W-1] ^ op;
  assign w_ea = a[W-2:MAN_W];
  assign w_eb = b[W-2:MAN_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];

  assign w_a_nan = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_inf = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf = (w_eb == EMAX) && (w_fb == '0);
  assign w_spec  = w_a_nan | w_b_nan | w_a_inf | w_b_inf;

  // denormals are flushed to zero before the magnitude compare
  assign w_mag_a = (w_ea == '0) ? '0 : a[W-2:0];
  assign w_mag_b = (w_eb == '0) ? '0 : b[W-2:0];
  assign w_swap  = w_mag_b > w_mag_a;
  assign w_mag_l = w_swap ? w_mag_b : w_mag_a;
  assign w_mag_s = w_swap ? w_mag_a : w_mag_b;
  assign w_sl    = w_swap ? w_sb : w_sa;
  assign w_ss    = w_swap ? w_sa : w_sb;
  assign w_el    = w_mag_l[W-2:MAN_W];
  assign w_es    = w_mag_s[W-2:MAN_W];
  assign w_ml    = (w_el == '0) ? '0 : {1'b1, w_mag_l[MAN_W-1:0]};
  assign w_ms    = (w_es == '0) ? '0 : {1'b1, w_mag_s[MAN_W-1:0]};
  assign w_d     = w_el - w_es;

  // low half of the wide shift holds the bits lost to sticky
  assign w_sh    = {w_ms, 3'b000, {MW{1'b0}}} >> w_d;
  assign w_ms_al = (w_d >= SHMAX) ?
    {{(MW-1){1'b0}}, |w_ms} :
    {w_sh[2*MW-1:MW+1], w_sh[MW] | (|w_sh[MW-1:0])};

  // special-value result, bypasses the arithmetic path
  always_comb begin
    w_spec_res = QNAN;
    w_spec_inv = 1'b0;
    if (w_a_nan | w_b_nan) begin
      w_spec_res = QNAN;
    end else if (w_a_inf & w_b_inf) begin
      if (w_sa == w_sb)
        w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
      else
        w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  logic             r1_valid, r1_spec, r1_inv, r1_sign, r1_sub;
  logic [W-1:0]     r1_spec_res;
  logic [EXP_W-1:0] r1_exp;
  logic [MW-1:0]    r1_ml, r1_ms;

  // stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_spec     <= 1'b0;
      r1_inv      <= 1'b0;
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_spec_res <= '0;
      r1_exp      <= '0;
      r1_ml       <= '0;
      r1_ms       <= '0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_spec     <= w_spec;
      r1_inv      <= w_spec_inv;
      r1_sign     <= w_sl;
      r1_sub      <= w_sl ^ w_ss;
      r1_spec_res <= w_spec_res;
      r1_exp      <= w_el;
      r1_ml       <= {w_ml, 3'b000};
      r1_ms       <= w_ms_al;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [MW:0] w_sum;

  assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms}) :
                          ({1'b0, r1_ml} + {1'b0, r1_ms});

  logic             r2_valid, r2_spec, r2_inv, r2_sign, r2_sub;
  logic [W-1:0]     r2_spec_res;
  logic [EXP_W-1:0] r2_exp;
  logic [MW:0]      r2_sum;

  // stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid    <= 1'b0;
      r2_spec     <= 1'b0;
      r2_inv      <= 1'b0;
      r2_sign     <= 1'b0;
      r2_sub      <= 1'b0;
      r2_spec_res <= '0;
      r2_exp      <= '0;
      r2_sum      <= '0;
    end else if (w_adv) begin
      r2_valid    <= r1_valid;
      r2_spec     <= r1_spec;
      r2_inv      <= r1_inv;
      r2_sign     <= r1_sign;
      r2_sub      <= r1_sub;
      r2_spec_res <= r1_spec_res;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
    end
  end

  // ---------------- stage 3: normalise / round / pack ----------------
  logic [LZW-1:0]   w_lz;
  logic [MW-1:0]    w_norm;
  logic [EW-1:0]    w_en, w_ef;
  logic             w_rnd_up, w_inexact;
  logic [MAN_W+1:0] w_mr;
  logic [MAN_W-1:0] w_frac;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flg;

  // leading-zero count of the uncarried sum (highest set bit wins)
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < MW; i++)
      if (r2_sum[i]) w_lz = LZW'(MW - 1 - i);
  end

  // bring the hidden bit to the top of the datapath
  always_comb begin
    w_norm = '0;
    w_en   = '0;
    if (r2_sum[MW]) begin
      w_norm = {r2_sum[MW:2], r2_sum[1] | r2_sum[0]};
      w_en   = {2'b00, r2_exp} + EW'(1);
    end else begin
      w_norm = r2_sum[MW-1:0] << w_lz;
      w_en   = {2'b00, r2_exp} - EW'(w_lz);
    end
  end

  assign w_inexact = |w_norm[2:0];
  assign w_rnd_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mr      = {1'b0, w_norm[MW-1:3]} +
                     {{(MAN_W+1){1'b0}}, w_rnd_up};
  assign w_ef      = w_mr[MAN_W+1] ? w_en + EW'(1) : w_en;
  assign w_frac    = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

  // final result selection: specials, exact zero, range limits
  always_comb begin
    w_res = {r2_sign, w_ef[EXP_W-1:0], w_frac};
    w_flg = {3'b000, w_inexact};
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_flg = {r2_inv, 3'b000};
    end else if (r2_sum == '0) begin
      w_res = {r2_sign & ~r2_sub, {(W-1){1'b0}}};
      w_flg = 4'b0000;
    end else if (!w_ef[EW-1] && (w_ef >= {2'b00, EMAX})) begin
      w_res = {r2_sign, EMAX, {MAN_W{1'b0}}};
      w_flg = 4'b0101;
    end else if (w_ef[EW-1] || (w_ef == '0)) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_flg = 4'b0011;
    end
  end

  logic         r3_valid;
  logic [W-1:0] r3_res;
  logic [3:0]   r3_flg;

  // output register, held while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_res   <= '0;
      r3_flg   <= '0;
    end else if (w_adv) begin
      r3_valid <= r2_valid;
      r3_res   <= w_res;
      r3_flg   <= w_flg;
    end
  end

  assign w_adv     = out_ready | ~r3_valid;
  assign in_ready  = w_adv;
  assign out_valid = r3_valid;
  assign result    = r3_res;
  assign flags     = r3_flg;

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshake on both sides.
- Generalises the combinational single-precision adder in three ways: configurable exponent/mantissa widths, an add/sub mode bit, and correct alignment, normalisation, round-to-nearest-even and special-value handling.
- Sits between an operand source (register file / FIFO) and a result sink in the arithmetic datapath.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width (hidden 1 implied).
- W, EXP_W+MAN_W+1, total word width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- op  in  1  0 = A+B, 1 = A-B (B sign inverted at entry)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- result  out  W  rounded sum
- flags  out  4  {invalid, overflow, underflow, inexact} for result

Behaviour:
- Reset (async, rst_n=0): all stage valid bits cleared; out_valid=0, result=0, flags=0, in_ready=1 once rst_n deasserts. Reset mid-operation discards all in-flight operations; nothing is emitted afterwards for them.
- Pipeline advance: adv = out_ready | ~out_valid. in_ready = adv. When adv=0 all stages hold (global stall); no bubble compaction needed. Transfer on in_valid&in_ready; output consumed on out_valid&out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid when never stalled; throughput 1 per cycle.
- Stage 1 (unpack/align): apply op to sign_b; exp==0 inputs treated as signed zero (denormals flushed); swap so |A|>=|B| (compare {exp,frac}); shift smaller mantissa right by exp difference into MAN_W+4 bits (hidden, frac, guard, round, sticky); shifts >= MAN_W+3 collapse to sticky only. Classify NaN/Inf/zero.
- Stage 2 (add): same effective sign -> add; different -> subtract (never negative after swap). Result sign = sign of larger-magnitude operand.
- Stage 3 (normalise/round/pack): carry-out -> shift right 1, exp+1 (sticky ORed); otherwise leading-zero count and left shift, exp decremented. RNE on guard/round/sticky; rounding carry renormalises.
- Exact-zero result from differing signs: +0. (-0)+(-0) = -0.
- Overflow: exp >= 2^EXP_W-1 -> ±Inf, overflow=1, inexact=1.
- Underflow: normalised exp <= 0 -> signed zero, underflow=1, inexact=1 (flush, no denormal output).
- Specials (bypass arithmetic): any NaN -> canonical quiet NaN {0, all-ones exp, MSB frac=1, rest 0}; Inf + Inf same sign -> that Inf; Inf - Inf -> canonical NaN, invalid=1; Inf + finite -> Inf.
- inexact=1 whenever any of guard/round/sticky were nonzero before rounding.
- result/flags hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Defaults, a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000 after 3 cycles, flags=0.
- a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000 (+0), flags=0; a=0x80000000 + b=0x80000000, op=0 -> 0x80000000.
- RNE: 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1; 0x3F800000 + 0x34400000 -> 0x3F800002, inexact=1.
- Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
- Backpressure: stream 6 back-to-back ops with out_ready toggling 1,0,0,1,... -> results emitted in order, none lost or duplicated, in_ready=0 exactly when out_valid&~out_ready.
- Reset mid-stream with 3 ops in flight -> out_valid=0 immediately; no stale results emitted after rst_n rises. Repeat the first scenario with EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 -> 0x4200.
